// File: rtl/uart_rx_if.sv
// Receive-side bundle between the rx pad logic and the I/O register consumer.
// master = the receiver, slave = the consumer that drives rx and rx_ack.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  // rx_avail stays high until the consumer returns a one-cycle rx_ack; an ack
  // while rx_avail is low is ignored, and a byte landing on the ack cycle wins.
  modport master (
    input  rx, rx_ack,
    output rx_data, rx_avail, frame_err, overrun, busy, dbg_state
  );

  modport slave (
    output rx, rx_ack,
    input  rx_data, rx_avail, frame_err, overrun, busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling from a divisor
// counter, and a one-byte holding register with avail/ack handshake.
module uart_rx #(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int D  = clk_freq / baud;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(D / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(D - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitn;
  logic [7:0]    r_shreg;
  logic [7:0]    r_rx_data;
  logic          r_rx_avail;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_busy;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rxs;
  logic          w_cnt_zero;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs      = r_sync2;
  assign w_cnt_zero = (r_cnt == CNT_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_bitn      <= 3'd0;
      r_shreg     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_avail  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (bus.rx_ack) begin
        r_rx_avail <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= CNT_HALF;
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_cnt_zero) begin
            if (w_rxs) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt   <= CNT_FULL;
              r_bitn  <= 3'd0;
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_DATA: begin
          if (w_cnt_zero) begin
            r_shreg <= {w_rxs, r_shreg[7:1]};
            r_cnt   <= CNT_FULL;
            if (r_bitn == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bitn <= r_bitn + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        // Leaving at mid-stop-bit gives half a bit of slack before the next start edge.
        S_STOP: begin
          if (w_cnt_zero) begin
            if (w_rxs) begin
              r_rx_data  <= r_shreg;
              r_rx_avail <= 1'b1;
              r_overrun  <= r_rx_avail && !bus.rx_ack;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_BREAK: begin
          if (w_rxs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_avail  = r_rx_avail;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state;

endmodule
